// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    // Arbiter FSM states: waiting for a request, waiting for uart_tx to start,
    // and waiting for the frame to finish.
    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_LAUNCH = 2'd1,
        A_BUSY   = 2'd2
    } arb_state_t;

    // Payload width of one UART frame.
    localparam int UART_DW = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: starting at ptr, returns the first
// pending requester as a one-hot vector and as a binary index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    // cand[gi] is the requester examined at search offset gi from ptr.
    // The wrap is computed explicitly so N_REQ need not be a power of two.
    logic [PW-1:0]    cand [N_REQ];
    logic [N_REQ-1:0] hit;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum       = {1'b0, ptr} + (PW+1)'(gi);
            assign cand[gi]  = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ))
                                                       : sum[PW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Lowest search offset with a pending request wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                valid = 1'b1;
                idx   = cand[i];
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers,
// with optional locked bursts and a launch timeout that sets a sticky error.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int LAUNCH_TO = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         lock_i,
    input  logic [UART_DW*N_REQ-1:0] data_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic                     tx_start,
    output logic [UART_DW-1:0]       tx_data,
    input  logic                     tx_idle
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int TW = (LAUNCH_TO > 0) ? $clog2(LAUNCH_TO + 1) : 1;

    arb_state_t         state_reg, state_next;
    logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]      owner_reg, owner_next;
    logic [BW-1:0]      burst_cnt_reg, burst_cnt_next;
    logic [TW-1:0]      to_cnt_reg, to_cnt_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [UART_DW-1:0] data_reg, data_next;
    logic               err_reg, err_next;
    logic               start_reg, start_next;

    logic [UART_DW-1:0] data_lane [N_REQ];
    logic [N_REQ-1:0]   win_onehot;
    logic [PW-1:0]      win_idx;
    logic               win_valid;
    logic [PW-1:0]      ptr_after;

    // Split the flat data bus into per-requester byte lanes.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign data_lane[gi] = data_i[gi*UART_DW +: UART_DW];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req    (req_i),
        .ptr    (rr_ptr_reg),
        .onehot (win_onehot),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    // The requester after the current owner starts the next search.
    assign ptr_after = (owner_reg == PW'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

    // State, counters and the captured payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= A_IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            grant_reg     <= '0;
            data_reg      <= '0;
            err_reg       <= 1'b0;
            start_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            grant_reg     <= grant_next;
            data_reg      <= data_next;
            err_reg       <= err_next;
            start_reg     <= start_next;
        end
    end

    // Next-state logic; tx_start is registered so it is high only on the
    // first cycle of A_LAUNCH.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        grant_next     = grant_reg;
        data_next      = data_reg;
        err_next       = err_reg;
        start_next     = 1'b0;
        ack_o          = '0;

        case (state_reg)
            A_IDLE: begin
                if (win_valid && tx_idle) begin
                    owner_next  = win_idx;
                    grant_next  = win_onehot;
                    data_next   = data_lane[win_idx];
                    to_cnt_next = TW'(LAUNCH_TO);
                    start_next  = 1'b1;
                    state_next  = A_LAUNCH;
                end
            end
            A_LAUNCH: begin
                if (!tx_idle) begin
                    // uart_tx has taken the byte.
                    ack_o      = grant_reg;
                    state_next = A_BUSY;
                end else if (to_cnt_reg == '0) begin
                    // uart_tx never started: flag it and move on to the next requester.
                    err_next       = 1'b1;
                    rr_ptr_next    = ptr_after;
                    grant_next     = '0;
                    burst_cnt_next = '0;
                    state_next     = A_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg - 1'b1;
                end
            end
            A_BUSY: begin
                if (tx_idle) begin
                    if (lock_i[owner_reg] && req_i[owner_reg] &&
                        (burst_cnt_reg < BW'(MAX_BURST - 1))) begin
                        // Locked owner keeps the line for another byte.
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                        data_next      = data_lane[owner_reg];
                        to_cnt_next    = TW'(LAUNCH_TO);
                        start_next     = 1'b1;
                        state_next     = A_LAUNCH;
                    end else begin
                        burst_cnt_next = '0;
                        rr_ptr_next    = ptr_after;
                        grant_next     = '0;
                        state_next     = A_IDLE;
                    end
                end
            end
            default: begin
                state_next = A_IDLE;
            end
        endcase
    end

    assign grant_o  = grant_reg;
    assign busy_o   = (state_reg != A_IDLE);
    assign err_o    = err_reg;
    assign tx_start = start_reg;
    assign tx_data  = data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Two arbiters run side by side
// (MAX_BURST 16 and 2), each with a small uart_tx model and client model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   [2];
    logic [N-1:0]   lock  [2];
    logic [8*N-1:0] data  [2];
    logic [N-1:0]   ack   [2];
    logic [N-1:0]   grant [2];
    logic [7:0]     txd   [2];
    logic [1:0]     busy;
    logic [1:0]     err;
    logic [1:0]     tx_start;
    logic [1:0]     tx_idle;
    logic [1:0]     dead = 2'b00;

    // Client model: per instance, per requester, up to 4 queued bytes.
    logic [7:0] cbytes   [2][N][4];
    int         chead    [2][N];
    int         ccnt     [2][N];
    logic       clock_en [2][N];
    logic [7:0] cidle    [2][N];

    // Accepted bytes as {requester index, byte}.
    logic [11:0] log0[$];
    logic [11:0] log1[$];
    int          viol = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic [4:0] ucnt = '0;

            uart_tx_arbiter #(
                .N_REQ     (N),
                .MAX_BURST ((gi == 0) ? 16 : 2),
                .LAUNCH_TO (15)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .req_i    (req[gi]),
                .lock_i   (lock[gi]),
                .data_i   (data[gi]),
                .ack_o    (ack[gi]),
                .grant_o  (grant[gi]),
                .busy_o   (busy[gi]),
                .err_o    (err[gi]),
                .tx_start (tx_start[gi]),
                .tx_data  (txd[gi]),
                .tx_idle  (tx_idle[gi])
            );

            // uart_tx model: idle drops 2 clk after tx_start, stays low 20 clk.
            always @(posedge clk) begin
                if (!rst_n) begin
                    ucnt <= '0;
                end else if (ucnt != 5'd0) begin
                    ucnt <= (ucnt == 5'd21) ? 5'd0 : ucnt + 5'd1;
                end else if (tx_start[gi] && !dead[gi]) begin
                    ucnt <= 5'd1;
                end
            end
            assign tx_idle[gi] = (ucnt < 5'd2);
        end
    endgenerate

    function automatic logic [3:0] onehot_idx(input logic [N-1:0] v);
        logic [3:0] r = 4'hF;
        for (int k = 0; k < N; k++) begin
            if (v[k]) r = 4'(k);
        end
        return r;
    endfunction

    // Monitor then client update, on the falling edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ack[u] != '0) begin
                logic [3:0] ix;
                ix = onehot_idx(ack[u]);
                if (u == 0) log0.push_back({ix, txd[u]});
                else        log1.push_back({ix, txd[u]});
                if ($countones(ack[u]) != 1 || ack[u] != grant[u]) viol++;
                if (ix < N && chead[u][ix] < ccnt[u][ix]) chead[u][ix]++;
            end
            if (tx_start[u] && !tx_idle[u]) viol++;
            for (int k = 0; k < N; k++) begin
                req[u][k]        = (chead[u][k] < ccnt[u][k]);
                lock[u][k]       = clock_en[u][k] && req[u][k];
                data[u][8*k +: 8] = req[u][k] ? cbytes[u][k][chead[u][k]] : cidle[u][k];
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    function automatic int log_size(input int u);
        return (u == 0) ? log0.size() : log1.size();
    endfunction

    function automatic logic [11:0] log_at(input int u, input int i);
        if (u == 0) return (i < log0.size()) ? log0[i] : 12'hFFF;
        return (i < log1.size()) ? log1[i] : 12'hFFF;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_bench();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < N; k++) begin
                chead[u][k]    = 0;
                ccnt[u][k]     = 0;
                clock_en[u][k] = 1'b0;
                cidle[u][k]    = 8'h00;
            end
        end
        log0.delete();
        log1.delete();
        dead = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic load(input int u, input int k, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int n, input logic lk);
        cbytes[u][k][0] = b0;
        cbytes[u][k][1] = b1;
        cbytes[u][k][2] = b2;
        chead[u][k]     = 0;
        ccnt[u][k]      = n;
        clock_en[u][k]  = lk;
    endtask

    task automatic wait_log(input int u, input int n, input int budget);
        int c = 0;
        while (log_size(u) < n && c < budget) begin
            step(1);
            c++;
        end
        check_value("wait_log", 32'(log_size(u) >= n), 32'd1);
    endtask

    task automatic wait_idle(input int u, input int budget);
        int c = 0;
        while (busy[u] && c < budget) begin
            step(1);
            c++;
        end
        check_value("wait_idle", 32'(busy[u]), 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req[u]  = '0;
            lock[u] = '0;
            data[u] = '0;
        end
        clear_bench();
        do_reset();

        // Reset state
        check_value("rst_state", 32'({grant[0], ack[0], busy[0], err[0], tx_start[0], txd[0]}), 32'd0);

        // 1: single byte from requester 1
        load(0, 1, 8'hA5, 8'h00, 8'h00, 1, 1'b0);
        step(1);
        check_value("t1_start", 32'(tx_start[0]), 32'd1);
        check_value("t1_data", 32'(txd[0]), 32'hA5);
        check_value("t1_grant", 32'(grant[0]), 32'b0010);
        step(1);
        check_value("t1_start_once", 32'({tx_start[0], ack[0]}), 32'd0);
        step(1);
        check_value("t1_ack", 32'(ack[0]), 32'b0010);
        step(20);
        check_value("t1_busy_frame", 32'(busy[0]), 32'd1);
        step(1);
        check_value("t1_busy_done", 32'(busy[0]), 32'd0);
        check_value("t1_acks", 32'(log_size(0)), 32'd1);
        check_value("t1_log", 32'(log_at(0, 0)), 32'h1A5);

        // 2: all four held, two bytes each, no lock
        do_reset();
        for (int k = 0; k < N; k++) begin
            load(0, k, 8'hB0 + 8'(k), 8'hC0 + 8'(k), 8'h00, 2, 1'b0);
        end
        wait_log(0, 8, 600);
        for (int i = 0; i < 8; i++) begin
            logic [11:0] exp;
            exp = {4'(i % 4), ((i < 4) ? 8'hB0 : 8'hC0) + 8'(i % 4)};
            check_value($sformatf("t2_order%0d", i), 32'(log_at(0, i)), 32'(exp));
        end

        // 3: locked burst on req0 with req2 waiting, both burst limits
        do_reset();
        for (int u = 0; u < 2; u++) begin
            load(u, 0, 8'h11, 8'h22, 8'h33, 3, 1'b1);
            load(u, 2, 8'h44, 8'h00, 8'h00, 1, 1'b0);
        end
        wait_log(0, 4, 400);
        wait_log(1, 4, 400);
        check_value("t3_b16_0", 32'(log_at(0, 0)), 32'h011);
        check_value("t3_b16_1", 32'(log_at(0, 1)), 32'h022);
        check_value("t3_b16_2", 32'(log_at(0, 2)), 32'h033);
        check_value("t3_b16_3", 32'(log_at(0, 3)), 32'h244);
        check_value("t3_b2_0", 32'(log_at(1, 0)), 32'h011);
        check_value("t3_b2_1", 32'(log_at(1, 1)), 32'h022);
        check_value("t3_b2_2", 32'(log_at(1, 2)), 32'h244);
        check_value("t3_b2_3", 32'(log_at(1, 3)), 32'h033);

        // 4: uart_tx never leaves idle -> timeout error
        do_reset();
        dead[0] = 1'b1;
        load(0, 1, 8'h5A, 8'h00, 8'h00, 1, 1'b0);
        load(0, 2, 8'h6B, 8'h00, 8'h00, 1, 1'b0);
        step(1);
        check_value("t4_start", 32'({tx_start[0], grant[0]}), 32'h12);
        step(15);
        check_value("t4_err_early", 32'(err[0]), 32'd0);
        step(1);
        check_value("t4_err", 32'(err[0]), 32'd1);
        check_value("t4_grant_clr", 32'({busy[0], grant[0]}), 32'd0);
        check_value("t4_no_ack", 32'(log_size(0)), 32'd0);
        dead[0] = 1'b0;
        wait_log(0, 2, 300);
        check_value("t4_next", 32'(log_at(0, 0)), 32'h26B);
        check_value("t4_retry", 32'(log_at(0, 1)), 32'h15A);
        check_value("t4_err_sticky", 32'(err[0]), 32'd1);

        // 5: reset during a locked burst
        do_reset();
        load(0, 0, 8'hD1, 8'hD2, 8'hD3, 3, 1'b1);
        wait_log(0, 1, 100);
        step(5);
        check_value("t5_in_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        clear_bench();
        step(1);
        check_value("t5_rst_out", 32'({grant[0], ack[0], busy[0], err[0], tx_start[0], txd[0]}), 32'd0);
        rst_n = 1'b1;
        load(0, 3, 8'h3C, 8'h00, 8'h00, 1, 1'b0);
        step(1);
        check_value("t5_grant", 32'({grant[0], txd[0]}), 32'h83C);
        wait_log(0, 1, 100);
        check_value("t5_log", 32'(log_at(0, 0)), 32'h33C);

        // 6: requester drops req and changes data right after grant
        do_reset();
        load(0, 1, 8'h77, 8'h00, 8'h00, 1, 1'b0);
        step(1);
        check_value("t6_grant", 32'(grant[0]), 32'b0010);
        ccnt[0][1]  = 0;
        cidle[0][1] = 8'hFF;
        wait_idle(0, 100);
        check_value("t6_acks", 32'(log_size(0)), 32'd1);
        check_value("t6_log", 32'(log_at(0, 0)), 32'h177);

        check_value("protocol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
